// File: rtl/mem_rsp_join.sv
// mem_rsp_join: joins per-beat {last, is_write} metadata with buffered memory responses,
// producing AXI R beats and one B per write burst. Define MEM_RSP_JOIN_ERR_EN to carry mem_err_i.
module mem_rsp_join #(
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 4,
  parameter int CNT_W      = $clog2(RSP_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            meta_data_i,
  input  logic                  meta_valid_i,
  output logic                  meta_ready_o,
  input  logic                  mem_req_i,
  output logic                  req_allow_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_err_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_last_o,
  output logic                  b_valid_o,
  input  logic                  b_ready_i,
  output logic [1:0]            b_resp_o,
  output logic [1:0]            dbg_state_o
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // a raised valid and its payload hold steady until that edge.
  localparam int PTR_W = $clog2(RSP_DEPTH);

  typedef enum logic [1:0] {
    ST_JOIN  = 2'd0,
    ST_R_OUT = 2'd1,
    ST_B_OUT = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_buf_data [RSP_DEPTH];
  logic [PTR_W:0]        r_wptr;
  logic [PTR_W:0]        r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_rlast;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_head_err;
  logic                  w_burst_err;
  logic [DATA_WIDTH-1:0] w_head_data;

  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                       (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_push      = mem_rvalid_i && !w_full;
  assign w_pop       = (r_state == ST_JOIN) && meta_valid_i && !w_empty;
  assign w_head_data = r_buf_data[r_rptr[PTR_W-1:0]];

  always_ff @(posedge clk_i) begin
    if (w_push) r_buf_data[r_wptr[PTR_W-1:0]] <= mem_rdata_i;
  end

`ifdef MEM_RSP_JOIN_ERR_EN
  logic [RSP_DEPTH-1:0] r_buf_err;
  logic                 r_sticky;

  assign w_head_err  = r_buf_err[r_rptr[PTR_W-1:0]];
  assign w_burst_err = r_sticky | w_head_err;

  always_ff @(posedge clk_i) begin
    if (w_push) r_buf_err[r_wptr[PTR_W-1:0]] <= mem_err_i;
  end

  // Sticky collects errors across a write burst and clears once its B is formed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sticky <= 1'b0;
    end else if (w_pop && meta_data_i[0]) begin
      r_sticky <= meta_data_i[1] ? 1'b0 : w_burst_err;
    end
  end
`else
  logic w_unused_err;
  assign w_unused_err = mem_err_i;
  assign w_head_err   = 1'b0;
  assign w_burst_err  = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (PTR_W+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (PTR_W+1)'(1);
    end
  end

  // Credits cover both in-flight and buffered responses, so the buffer cannot overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (mem_req_i && !w_pop) begin
      if (r_count != CNT_W'(RSP_DEPTH)) r_count <= r_count + CNT_W'(1);
    end else if (w_pop && !mem_req_i) begin
      if (r_count != '0) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_JOIN;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
      r_rlast  <= 1'b0;
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
    end else begin
      case (r_state)
        ST_JOIN: begin
          if (w_pop && !meta_data_i[0]) begin
            r_rdata  <= w_head_data;
            r_rlast  <= meta_data_i[1];
            r_rresp  <= w_head_err ? 2'b10 : 2'b00;
            r_rvalid <= 1'b1;
            r_state  <= ST_R_OUT;
          end else if (w_pop && meta_data_i[1]) begin
            r_bresp  <= w_burst_err ? 2'b10 : 2'b00;
            r_bvalid <= 1'b1;
            r_state  <= ST_B_OUT;
          end
        end
        ST_R_OUT: begin
          if (r_ready_i) begin
            r_rvalid <= 1'b0;
            r_state  <= ST_JOIN;
          end
        end
        ST_B_OUT: begin
          if (b_ready_i) begin
            r_bvalid <= 1'b0;
            r_state  <= ST_JOIN;
          end
        end
        default: r_state <= ST_JOIN;
      endcase
    end
  end

  assign meta_ready_o = w_pop;
  assign req_allow_o  = (r_count < CNT_W'(RSP_DEPTH));
  assign r_valid_o    = r_rvalid;
  assign r_data_o     = r_rdata;
  assign r_resp_o     = r_rresp;
  assign r_last_o     = r_rlast;
  assign b_valid_o    = r_bvalid;
  assign b_resp_o     = r_bresp;
  assign dbg_state_o  = r_state;

  // A request in the same cycle as a pop reuses the credit being returned.
  assert property (@(posedge clk_i) disable iff (rst_i) !(mem_rvalid_i && w_full))
    else $error("mem_rsp_join: response arrived with buffer full");
  assert property (@(posedge clk_i) disable iff (rst_i) !(mem_req_i && !req_allow_o && !w_pop))
    else $error("mem_rsp_join: request issued without credit");

endmodule

// File: tb/tb_mem_rsp_join.sv
// Testbench for mem_rsp_join: directed scenarios plus randomized traffic against a
// transaction-level model (response queue, credit count, expected R/B queues).
module tb_mem_rsp_join;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
`ifdef MEM_RSP_JOIN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [1:0]    meta_data_i;
  logic          meta_valid_i;
  logic          meta_ready_o;
  logic          mem_req_i;
  logic          req_allow_o;
  logic          mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_err_i;
  logic          r_valid_o;
  logic          r_ready_i;
  logic [DW-1:0] r_data_o;
  logic [1:0]    r_resp_o;
  logic          r_last_o;
  logic          b_valid_o;
  logic          b_ready_i;
  logic [1:0]    b_resp_o;
  logic [1:0]    dbg_state_o;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: expected R beats {resp, last, data} and expected B responses.
  logic [DW+2:0] exp_q[$];
  logic [1:0]    exp_b_q[$];

  mem_rsp_join #(.DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .meta_data_i(meta_data_i), .meta_valid_i(meta_valid_i), .meta_ready_o(meta_ready_o),
    .mem_req_i(mem_req_i), .req_allow_o(req_allow_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_resp_o(b_resp_o),
    .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  task automatic clear_inputs();
    meta_data_i = 2'b00; meta_valid_i = 1'b0; mem_req_i = 1'b0; mem_rvalid_i = 1'b0;
    mem_rdata_i = '0; mem_err_i = 1'b0; r_ready_i = 1'b0; b_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++; if ({r_valid_o, b_valid_o, meta_ready_o, req_allow_o} !== 4'b0001) begin failures++; $display("FAIL reset_flags got=%b exp=0001", {r_valid_o, b_valid_o, meta_ready_o, req_allow_o}); end
    checks++; if ({r_data_o, r_resp_o, r_last_o, b_resp_o} !== '0) begin failures++; $display("FAIL reset_payload got=%h exp=0", {r_data_o, r_resp_o, r_last_o, b_resp_o}); end
    checks++; if (dbg_state_o !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state_o); end
    @(negedge clk_i);
    meta_valid_i = 1'b1; meta_data_i = 2'b10;
    #1;
    checks++; if (meta_ready_o !== 1'b0) begin failures++; $display("FAIL reset_empty_meta_ready got=%b exp=0", meta_ready_o); end
    @(negedge clk_i);
    clear_inputs();
  endtask

  task automatic test_single_read();
    @(negedge clk_i);
    mem_req_i = 1'b1;
    #1;
    checks++; if (req_allow_o !== 1'b1) begin failures++; $display("FAIL rd_allow got=%b exp=1", req_allow_o); end
    @(negedge clk_i);
    mem_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA5A5_0001; mem_err_i = 1'b0;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0; meta_valid_i = 1'b1; meta_data_i = 2'b10;
    #1;
    checks++; if ({meta_ready_o, r_valid_o} !== 2'b10) begin failures++; $display("FAIL rd_join got=%b exp=10", {meta_ready_o, r_valid_o}); end
    @(negedge clk_i);
    meta_valid_i = 1'b0;
    #1;
    checks++; if ({r_valid_o, r_data_o, r_last_o, r_resp_o} !== {1'b1, 32'hA5A5_0001, 1'b1, 2'b00}) begin failures++; $display("FAIL rd_beat got=%h exp=%h", {r_valid_o, r_data_o, r_last_o, r_resp_o}, {1'b1, 32'hA5A5_0001, 1'b1, 2'b00}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      #1;
      checks++; if ({r_valid_o, r_data_o, r_last_o, r_resp_o, meta_ready_o} !== {1'b1, 32'hA5A5_0001, 1'b1, 2'b00, 1'b0}) begin failures++; $display("FAIL rd_hold%0d got=%h", i, {r_valid_o, r_data_o, r_last_o, r_resp_o, meta_ready_o}); end
    end
    @(negedge clk_i);
    r_ready_i = 1'b1;
    @(negedge clk_i);
    r_ready_i = 1'b0;
    #1;
    checks++; if ({r_valid_o, req_allow_o, dbg_state_o} !== 4'b0100) begin failures++; $display("FAIL rd_done got=%b exp=0100", {r_valid_o, req_allow_o, dbg_state_o}); end
  endtask

  task automatic run_write_burst(input int err_beat, input logic [1:0] exp_resp);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      mem_req_i = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      mem_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = $urandom; mem_err_i = (i == err_beat);
    end
    @(negedge clk_i);
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    #1;
    checks++; if (req_allow_o !== 1'b0) begin failures++; $display("FAIL wr_credit_full got=%b exp=0", req_allow_o); end
    for (int i = 0; i < 4; i++) begin
      meta_valid_i = 1'b1; meta_data_i = {1'(i == 3), 1'b1};
      #1;
      checks++; if ({meta_ready_o, r_valid_o, b_valid_o} !== 3'b100) begin failures++; $display("FAIL wr_beat%0d got=%b exp=100", i, {meta_ready_o, r_valid_o, b_valid_o}); end
      @(negedge clk_i);
    end
    meta_valid_i = 1'b0;
    #1;
    checks++; if ({b_valid_o, b_resp_o, r_valid_o, req_allow_o} !== {1'b1, exp_resp, 2'b01}) begin failures++; $display("FAIL wr_b got=%b exp=%b", {b_valid_o, b_resp_o, r_valid_o, req_allow_o}, {1'b1, exp_resp, 2'b01}); end
    @(negedge clk_i);
    #1;
    checks++; if ({b_valid_o, b_resp_o} !== {1'b1, exp_resp}) begin failures++; $display("FAIL wr_b_hold got=%b exp=%b", {b_valid_o, b_resp_o}, {1'b1, exp_resp}); end
    @(negedge clk_i);
    b_ready_i = 1'b1;
    @(negedge clk_i);
    b_ready_i = 1'b0;
    #1;
    checks++; if (b_valid_o !== 1'b0) begin failures++; $display("FAIL wr_b_done got=%b exp=0", b_valid_o); end
  endtask

  task automatic test_write_burst();
    run_write_burst(1, ERR_EN ? 2'b10 : 2'b00);
    run_write_burst(-1, 2'b00);
  endtask

  // Leaves the block in R_OUT with all four credits taken; test_reset_mid_burst follows on.
  task automatic test_credit_limit();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk_i);
      mem_req_i = 1'b1;
      #1;
      checks++; if (req_allow_o !== 1'b1) begin failures++; $display("FAIL credit_allow%0d got=%b exp=1", i, req_allow_o); end
    end
    @(negedge clk_i);
    mem_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_C0DE;
    #1;
    checks++; if (req_allow_o !== 1'b0) begin failures++; $display("FAIL credit_exhausted got=%b exp=0", req_allow_o); end
    @(negedge clk_i);
    mem_rvalid_i = 1'b0; meta_valid_i = 1'b1; meta_data_i = 2'b10; mem_req_i = 1'b1;
    #1;
    checks++; if ({meta_ready_o, req_allow_o} !== 2'b10) begin failures++; $display("FAIL credit_pop_req got=%b exp=10", {meta_ready_o, req_allow_o}); end
    @(negedge clk_i);
    meta_valid_i = 1'b0; mem_req_i = 1'b0;
    #1;
    checks++; if ({req_allow_o, r_valid_o, r_data_o} !== {2'b01, 32'h0000_C0DE}) begin failures++; $display("FAIL credit_hold got=%h exp=%h", {req_allow_o, r_valid_o, r_data_o}, {2'b01, 32'h0000_C0DE}); end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      mem_rvalid_i = 1'b1; mem_rdata_i = DW'(i + 1);
    end
    @(negedge clk_i);
    mem_rvalid_i = 1'b0; rst_i = 1'b1;
    #1;
    checks++; if ({dbg_state_o, r_valid_o} !== 3'b011) begin failures++; $display("FAIL rst_mid_pre got=%b exp=011", {dbg_state_o, r_valid_o}); end
    @(negedge clk_i);
    rst_i = 1'b0; meta_valid_i = 1'b1; meta_data_i = 2'b10;
    #1;
    checks++; if ({r_valid_o, b_valid_o, meta_ready_o, req_allow_o, dbg_state_o} !== 6'b000100) begin failures++; $display("FAIL rst_mid_post got=%b exp=000100", {r_valid_o, b_valid_o, meta_ready_o, req_allow_o, dbg_state_o}); end
    @(negedge clk_i);
    #1;
    checks++; if ({r_valid_o, b_valid_o} !== 2'b00) begin failures++; $display("FAIL rst_mid_stale got=%b exp=00", {r_valid_o, b_valid_o}); end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d;
    int idx;
    int cyc;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk_i);
      mem_req_i = 1'b1;
      #1;
      checks++; if (req_allow_o !== 1'b1) begin failures++; $display("FAIL bp_allow%0d got=%b exp=1", i, req_allow_o); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk_i);
      d = $urandom;
      mem_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = d;
      exp_q.push_back({2'b00, 1'(i == DEPTH - 1), d});
    end
    @(negedge clk_i);
    mem_rvalid_i = 1'b0; meta_valid_i = 1'b1; meta_data_i = 2'b00;
    #1;
    checks++; if (meta_ready_o !== 1'b1) begin failures++; $display("FAIL bp_first_join got=%b exp=1", meta_ready_o); end
    idx = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      meta_data_i = {1'(idx == DEPTH - 1), 1'b0};
      #1;
      checks++; if ({meta_ready_o, r_valid_o, r_data_o} !== {2'b01, exp_q[0][DW-1:0]}) begin failures++; $display("FAIL bp_stall%0d got=%h exp=%h", i, {meta_ready_o, r_valid_o, r_data_o}, {2'b01, exp_q[0][DW-1:0]}); end
    end
    r_ready_i = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      if (r_valid_o) begin
        checks++; if ({r_resp_o, r_last_o, r_data_o} !== exp_q[0]) begin failures++; $display("FAIL bp_beat got=%h exp=%h", {r_resp_o, r_last_o, r_data_o}, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      if (meta_ready_o) idx++;
      @(negedge clk_i);
      meta_valid_i = (idx < DEPTH);
      meta_data_i = {1'(idx == DEPTH - 1), 1'b0};
      #1;
      cyc++;
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_drain_timeout left=%0d exp=0", exp_q.size()); end
    clear_inputs();
    @(negedge clk_i);
    #1;
    checks++; if ({r_valid_o, req_allow_o} !== 2'b01) begin failures++; $display("FAIL bp_end got=%b exp=01", {r_valid_o, req_allow_o}); end
  endtask

  task automatic test_random();
    logic [DW:0] rsp_q[$];
    logic [DW:0] e;
    logic        exp_mr;
    logic        err;
    logic        cur_wr = 1'b0;
    logic        sticky = 1'b0;
    logic        hold = 1'b0;
    int outstanding = 0;
    int owed = 0;
    int issued = 0;
    int rem = 0;
    int cyc = 0;
    bit done = 1'b0;
    exp_q.delete();
    exp_b_q.delete();
    while (!done && cyc < 3000) begin
      @(negedge clk_i);
      if (rem == 0) begin
        cur_wr = 1'($urandom_range(0, 1));
        rem = $urandom_range(1, 4);
      end
      mem_req_i    = (issued < 100 && outstanding < DEPTH) ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rvalid_i = (owed > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata_i  = $urandom;
      mem_err_i    = ($urandom_range(0, 3) == 0);
      meta_valid_i = hold || (issued >= 100) || ($urandom_range(0, 3) != 0);
      meta_data_i  = {1'(rem == 1), cur_wr};
      r_ready_i    = 1'($urandom_range(0, 1));
      b_ready_i    = 1'($urandom_range(0, 1));
      #1;
      exp_mr = meta_valid_i && rsp_q.size() > 0 && exp_q.size() == 0 && exp_b_q.size() == 0;
      checks++; if (meta_ready_o !== exp_mr) begin failures++; $display("FAIL rnd_meta_ready cyc=%0d got=%b exp=%b", cyc, meta_ready_o, exp_mr); end
      checks++; if (req_allow_o !== (outstanding < DEPTH)) begin failures++; $display("FAIL rnd_allow cyc=%0d got=%b exp=%b", cyc, req_allow_o, outstanding < DEPTH); end
      checks++; if ({r_valid_o, b_valid_o} !== {exp_q.size() != 0, exp_b_q.size() != 0}) begin failures++; $display("FAIL rnd_valids cyc=%0d got=%b exp=%b", cyc, {r_valid_o, b_valid_o}, {exp_q.size() != 0, exp_b_q.size() != 0}); end
      if (exp_q.size() != 0) begin
        checks++; if ({r_resp_o, r_last_o, r_data_o} !== exp_q[0]) begin failures++; $display("FAIL rnd_r cyc=%0d got=%h exp=%h", cyc, {r_resp_o, r_last_o, r_data_o}, exp_q[0]); end
      end
      if (exp_b_q.size() != 0) begin
        checks++; if (b_resp_o !== exp_b_q[0]) begin failures++; $display("FAIL rnd_b cyc=%0d got=%b exp=%b", cyc, b_resp_o, exp_b_q[0]); end
      end
      // Advance the model across the coming rising edge.
      hold = meta_valid_i && !exp_mr;
      if (exp_q.size() != 0 && r_ready_i) void'(exp_q.pop_front());
      if (exp_b_q.size() != 0 && b_ready_i) void'(exp_b_q.pop_front());
      if (exp_mr) begin
        e = rsp_q.pop_front();
        err = ERR_EN && e[DW];
        if (!cur_wr) begin
          exp_q.push_back({err ? 2'b10 : 2'b00, 1'(rem == 1), e[DW-1:0]});
        end else if (rem == 1) begin
          exp_b_q.push_back((sticky || err) ? 2'b10 : 2'b00);
          sticky = 1'b0;
        end else begin
          sticky = sticky || err;
        end
        rem--;
      end
      outstanding += int'(mem_req_i) - int'(exp_mr);
      owed += int'(mem_req_i) - int'(mem_rvalid_i);
      issued += int'(mem_req_i);
      if (mem_rvalid_i) rsp_q.push_back({mem_err_i, mem_rdata_i});
      cyc++;
      done = (issued >= 100 && outstanding == 0 && owed == 0 && exp_q.size() == 0 && exp_b_q.size() == 0);
    end
    checks++; if (!done) begin failures++; $display("FAIL rnd_drain_timeout outstanding=%0d exp=0", outstanding); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_write_burst();
    test_credit_limit();
    test_reset_mid_burst();
    test_backpressure();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_rsp_join.md
Name: mem_rsp_join

Overview:
- Sits directly downstream of the 2-bit metadata stream FIFO in the axi_to_mem path.
- Joins per-beat metadata {last, is_write} with the memory response stream.
- Memory responses cannot be backpressured. They are buffered internally, and an outstanding-request credit counter throttles request issue upstream.
- Produces AXI R beats for reads and a single B response per write burst.

Parameters:
- DATA_WIDTH, 32, memory/AXI read data width.
- RSP_DEPTH, 4, internal response buffer depth and maximum outstanding memory requests (≥2, power of 2).
- CNT_W, $clog2(RSP_DEPTH+1), outstanding counter width.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- meta_data_i  in  2  bit0 = is_write, bit1 = last beat of burst
- meta_valid_i  in  1  metadata valid
- meta_ready_o  out  1  metadata accepted
- mem_req_i  in  1  a memory request issued this cycle (counts toward credits)
- req_allow_o  out  1  upstream may issue a memory request this cycle
- mem_rvalid_i  in  1  memory response valid, no backpressure
- mem_rdata_i  in  DATA_WIDTH  memory response data
- mem_err_i  in  1  memory response error
- r_valid_o  out  1  AXI R valid
- r_ready_i  in  1  AXI R ready
- r_data_o  out  DATA_WIDTH  AXI R data
- r_resp_o  out  2  AXI R resp
- r_last_o  out  1  AXI R last
- b_valid_o  out  1  AXI B valid
- b_ready_i  in  1  AXI B ready
- b_resp_o  out  2  AXI B resp

Behaviour:
- Reset (rst_i sampled high):
  - Buffer emptied; outstanding count = 0; error-sticky = 0; FSM in JOIN.
  - All valid/ready outputs = 0; data/resp/last outputs = 0.
  - req_allow_o = 1 from the first cycle after reset.
  - Reset mid-burst discards all buffered and held beats; no partial B is emitted.
- Response buffer:
  - FIFO of RSP_DEPTH entries, each {err, data}.
  - Written when mem_rvalid_i = 1.
  - A write while full is a protocol violation and triggers a simulation assertion; buffer contents are unchanged.
- Outstanding counter:
  - +1 on mem_req_i; −1 on buffer pop.
  - Both in the same cycle → unchanged.
  - req_allow_o = (count < RSP_DEPTH), combinational from the registered count.
  - mem_req_i while req_allow_o = 0 triggers an assertion; the counter saturates at RSP_DEPTH.
- FSM states:
  - JOIN, when meta_valid_i = 1 and the buffer is non-empty:
    - Read meta: latch data, err, and last into the R register; pop buffer; meta_ready_o = 1; next state R_OUT.
    - Write meta, last = 0: sticky |= err; pop buffer; meta_ready_o = 1; stay in JOIN.
    - Write meta, last = 1: b_resp = (sticky | err) ? 2'b10 : 2'b00; pop buffer; meta_ready_o = 1; clear sticky; next state B_OUT.
    - Otherwise: idle, meta_ready_o = 0.
  - R_OUT:
    - r_valid_o = 1 with stable r_data_o, r_last_o = latched last, r_resp_o = err ? 2'b10 : 2'b00.
    - On r_ready_i: return to JOIN.
  - B_OUT:
    - b_valid_o = 1 with stable b_resp_o.
    - On b_ready_i: return to JOIN.
- Latency and throughput:
  - 1 cycle from both heads available to r_valid_o / b_valid_o.
  - Read throughput is 1 beat per 2 cycles; write non-last beats consume 1 per cycle.
- meta_ready_o is 1 only in JOIN with the buffer non-empty. It never depends on r_ready_i or b_ready_i.
- Outputs stay stable while valid and not ready; no valid is dropped without a handshake.
- r_resp_o and b_resp_o are only ever OKAY (00) or SLVERR (10).

Optional Feature:
- MEM_RSP_JOIN_ERR_EN defined:
  - mem_err_i is stored per buffer entry and accumulated across write bursts.
  - Errors are reported as SLVERR.
- Not defined:
  - mem_err_i is ignored and not stored (buffer width = DATA_WIDTH).
  - The sticky register is removed; r_resp_o = b_resp_o = 2'b00 always.

Test Plan:
- Reset release → req_allow_o=1; r_valid_o=b_valid_o=meta_ready_o=0; count=0.
- Single read: mem_req_i pulse; rvalid with data 32'hA5A5_0001; meta {last=1, wr=0} → r_valid_o 1 cycle after join; r_data_o=A5A5_0001, r_last_o=1, r_resp_o=00. Hold r_ready_i=0 for 3 cycles → outputs stable.
- Write burst of 4, mem_err_i=1 on beat 2 (ERR_EN defined) → no R output; one b_valid_o with b_resp_o=10. A following clean burst → b_resp_o=00. With ERR_EN undefined → 00 both.
- Credit limit: issue RSP_DEPTH=4 requests, no responses → req_allow_o=0. One pop with simultaneous mem_req_i → count stays 4, req_allow_o stays 0.
- Backpressure: fill buffer with 4 read responses, hold r_ready_i=0 → meta_ready_o=0 after the first join; release → 4 beats in order.
- Reset asserted while in R_OUT with 3 entries buffered → next cycle: r_valid_o=0, buffer empty, count=0, req_allow_o=1.
